// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch queue.
//   INSTR_W / ADDR_W : default instruction and PC widths
//   fq_entry_t       : one stored (PC, instruction) pair
//   fq_ptr_w()       : pointer width for a given queue depth
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    function automatic int fq_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH-entry register array backing the fetch queue.
// One synchronous write port, one combinational read port, no reset
// (contents are only meaningful where the pointer/count logic says so).
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : entry to write
//   raddr_i  : read index
//   rdata_o  : entry at raddr_i (combinational)
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fq_entry_t,
    localparam int PW      = fq_ptr_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  entry_t        wdata_i,
    input  logic [PW-1:0] raddr_i,
    output entry_t        rdata_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode.
// Captures (PC, instruction) pairs from fetch, presents the oldest to
// decode, back-pressures fetch when full and drops everything on a
// taken branch.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN): when the queue is empty
// and decode is ready, a fetched instruction is forwarded to the D side in
// the same cycle without being stored.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   valid_F      : fetch presents an instruction
//   imem_addr_F  : PC of presented instruction
//   instr_F      : presented instruction word
//   ready_F      : queue can take a push (depends on occupancy only)
//   flush_D      : taken branch, discard all contents
//   valid_D      : head entry valid
//   pc_D/instr_D : head entry (zero when valid_D=0)
//   ready_D      : decode consumes the head
//   count_D      : current occupancy
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_F,
    input  logic [ADDR_W-1:0]          imem_addr_F,
    input  logic [INSTR_W-1:0]         instr_F,
    output logic                       ready_F,
    input  logic                       flush_D,
    output logic                       valid_D,
    output logic [ADDR_W-1:0]          pc_D,
    output logic [INSTR_W-1:0]         instr_D,
    input  logic                       ready_D,
    output logic [$clog2(DEPTH):0]     count_D
);

    localparam int PW = fetch_pkg::fq_ptr_w(DEPTH);
    localparam int CW = PW + 1;

    // Same layout as fetch_pkg::fq_entry_t, sized by this instance's widths.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic   stored_vld;
    logic   bypass;
    logic   push;
    logic   pop;
    entry_t wdata;
    entry_t rdata;

    assign stored_vld = (count_q != '0);
    // Full refuses a push even if a pop happens in the same cycle.
    assign ready_F    = (count_q != CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue + ready decode: hand the instruction straight through.
    assign bypass = ~stored_vld & valid_F & ready_D & ~flush_D;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction is consumed directly and never stored.
    assign push = valid_F & ready_F & ~flush_D & ~bypass;
    assign pop  = stored_vld & ready_D & ~flush_D;

    assign wdata.pc    = imem_addr_F;
    assign wdata.instr = instr_F;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_D) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally: DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push & ~reset),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Outputs are forced to zero when nothing valid is presented so that
    // stale storage contents never leak to decode.
    always_comb begin
        valid_D = stored_vld;
        pc_D    = '0;
        instr_D = '0;
        if (bypass) begin
            valid_D = 1'b1;
            pc_D    = imem_addr_F;
            instr_D = instr_F;
        end else if (stored_vld) begin
            pc_D    = rdata.pc;
            instr_D = rdata.instr;
        end
    end

    assign count_D = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4, ADDR_W=64, INSTR_W=32).
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_F = 1'b0;
    logic [63:0] imem_addr_F = '0;
    logic [31:0] instr_F = '0;
    logic        ready_F;
    logic        flush_D = 1'b0;
    logic        valid_D;
    logic [63:0] pc_D;
    logic [31:0] instr_D;
    logic        ready_D = 1'b0;
    logic [2:0]  count_D;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(64), .INSTR_W(32)) dut (
        .clk(clk), .reset(reset), .valid_F(valid_F), .imem_addr_F(imem_addr_F),
        .instr_F(instr_F), .ready_F(ready_F), .flush_D(flush_D), .valid_D(valid_D),
        .pc_D(pc_D), .instr_D(instr_D), .ready_D(ready_D), .count_D(count_D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vf;
        logic [63:0] pc;
        logic        fl;
        logic        rd;
        logic        chk;
        int          e_cnt;
        logic        e_vld;
        logic        e_rdy;
        logic [63:0] e_pc;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [31:0] mk_instr(input logic [63:0] pc);
        return 32'h8B000000 + pc[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected columns describe the cycle before the row's clock edge.
    task automatic add(input logic rst, input logic vf, input logic [63:0] pc,
                       input logic fl, input logic rd, input logic c, input int ecnt,
                       input logic evld, input logic erdy, input logic [63:0] epc);
        vec_t v;
        v.rst = rst; v.vf = vf; v.pc = pc; v.fl = fl; v.rd = rd; v.chk = c;
        v.e_cnt = ecnt; v.e_vld = evld; v.e_rdy = erdy; v.e_pc = epc;
        vecs.push_back(v);
    endtask

    initial begin
        int mc;
        //   rst vf  pc       fl rd chk cnt vld rdy pc
        add(1, 0, 64'h0,    0, 0, 0, 0, 0, 1, 64'h0);
        add(0, 0, 64'h0,    0, 0, 1, 0, 0, 1, 64'h0);   // idle after reset
        // fill to full, fifth push refused
        add(0, 1, 64'h0,    0, 0, 1, 0, 0, 1, 64'h0);
        add(0, 1, 64'h4,    0, 0, 1, 1, 1, 1, 64'h0);
        add(0, 1, 64'h8,    0, 0, 1, 2, 1, 1, 64'h0);
        add(0, 1, 64'hC,    0, 0, 1, 3, 1, 1, 64'h0);
        add(0, 1, 64'h10,   0, 0, 1, 4, 1, 0, 64'h0);
        add(0, 1, 64'h10,   0, 1, 1, 4, 1, 0, 64'h0);   // full + pop: still no push
        add(0, 0, 64'h0,    0, 1, 1, 3, 1, 1, 64'h4);
        add(0, 0, 64'h0,    0, 1, 1, 2, 1, 1, 64'h8);
        add(0, 0, 64'h0,    0, 1, 1, 1, 1, 1, 64'hC);
        add(0, 0, 64'h0,    0, 1, 1, 0, 0, 1, 64'h0);   // empty + ready_D: no underflow
        // streaming at count=2
        add(0, 1, 64'h20,   0, 0, 1, 0, 0, 1, 64'h0);
        add(0, 1, 64'h24,   0, 0, 1, 1, 1, 1, 64'h20);
        for (int k = 0; k < 10; k++)
            add(0, 1, 64'h28 + 64'(4*k), 0, 1, 1, 2, 1, 1, 64'h20 + 64'(4*k));
        // flush with 3 entries, concurrent push and pop discarded
        add(0, 1, 64'h50,   0, 0, 1, 2, 1, 1, 64'h48);
        add(0, 1, 64'h40,   1, 1, 1, 3, 1, 1, 64'h48);
        add(0, 0, 64'h0,    0, 0, 1, 0, 0, 1, 64'h0);
        add(0, 1, 64'h100,  0, 0, 1, 0, 0, 1, 64'h0);
        add(0, 0, 64'h0,    0, 0, 1, 1, 1, 1, 64'h100);
        // reset mid-stream with 3 entries and a push attempt
        add(0, 1, 64'h104,  0, 0, 1, 1, 1, 1, 64'h100);
        add(0, 1, 64'h108,  0, 0, 1, 2, 1, 1, 64'h100);
        add(1, 1, 64'h10C,  0, 0, 1, 3, 1, 1, 64'h100);
        add(0, 0, 64'h0,    0, 0, 1, 0, 0, 1, 64'h0);
        add(0, 0, 64'h0,    0, 0, 1, 0, 0, 1, 64'h0);

        mc = 0;
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            reset = v.rst; valid_F = v.vf; imem_addr_F = v.pc;
            instr_F = mk_instr(v.pc); flush_D = v.fl; ready_D = v.rd;
            #1;
            if (v.chk) begin
                chk($sformatf("count_D[%0d]", i), 64'(count_D), 64'(v.e_cnt));
                chk($sformatf("valid_D[%0d]", i), 64'(valid_D), 64'(v.e_vld));
                chk($sformatf("ready_F[%0d]", i), 64'(ready_F), 64'(v.e_rdy));
                chk($sformatf("pc_D[%0d]", i), pc_D, v.e_pc);
                if (!v.e_vld) chk($sformatf("instr_D_zero[%0d]", i), 64'(instr_D), 64'h0);
            end
            // scoreboard: pop on model-predicted consume, push on model-predicted accept
            if (v.rst || v.fl) begin
                sbq.delete();
            end else begin
                if (mc != 0 && v.rd) begin
                    chk($sformatf("sb_pc[%0d]", i), pc_D, sbq[0].pc);
                    chk($sformatf("sb_instr[%0d]", i), 64'(instr_D), 64'(sbq[0].instr));
                    void'(sbq.pop_front());
                end
                if (v.vf && mc != DEPTH) begin
                    exp_t e;
                    e.pc = v.pc; e.instr = mk_instr(v.pc);
                    sbq.push_back(e);
                end
            end
            mc = sbq.size();
        end

        // Bypass / latency corner case on an empty queue
        @(negedge clk);
        reset = 0; flush_D = 0; valid_F = 1; imem_addr_F = 64'h20;
        instr_F = mk_instr(64'h20); ready_D = 1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_valid_same", 64'(valid_D), 64'h1);
        chk("byp_pc_same", pc_D, 64'h20);
        chk("byp_instr_same", 64'(instr_D), 64'(mk_instr(64'h20)));
        chk("byp_count_same", 64'(count_D), 64'h0);
`else
        chk("lat_valid_same", 64'(valid_D), 64'h0);
        chk("lat_pc_same", pc_D, 64'h0);
        chk("lat_count_same", 64'(count_D), 64'h0);
`endif
        @(negedge clk);
        valid_F = 0; imem_addr_F = '0; instr_F = '0; ready_D = 1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_valid_next", 64'(valid_D), 64'h0);
        chk("byp_count_next", 64'(count_D), 64'h0);
`else
        chk("lat_valid_next", 64'(valid_D), 64'h1);
        chk("lat_pc_next", pc_D, 64'h20);
        chk("lat_instr_next", 64'(instr_D), 64'(mk_instr(64'h20)));
        chk("lat_count_next", 64'(count_D), 64'h1);
`endif
        @(negedge clk);
        ready_D = 0;
        #1;
        chk("final_count", 64'(count_D), 64'h0);
        chk("final_valid", 64'(valid_D), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
